// File: rtl/ev22_register_bank.sv
// EV22 register bank: general registers r0-r27, synchronised input ports
// (r28/r29), output ports (dest 30/31), auxiliaries r32/r33 and the working
// register (r34). One write-back per clock from the ALU result bus.
module ev22_register_bank #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Sel_C,
  input  logic             Write_En,
  input  logic [WIDTH-1:0] Data_C,
  input  logic [WIDTH-1:0] Port_In_0,
  input  logic [WIDTH-1:0] Port_In_1,
  output logic [WIDTH-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  output logic [WIDTH-1:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
  output logic [WIDTH-1:0] r16, r17, r18, r19, r20, r21, r22, r23,
  output logic [WIDTH-1:0] r24, r25, r26, r27, r28, r29, r32, r33,
  output logic [WIDTH-1:0] Working_Register,
  output logic [WIDTH-1:0] Output_Port_0,
  output logic [WIDTH-1:0] Output_Port_1,
  output logic             Illegal_Write,
  output logic [1:0]       Port_Changed
);

  logic [WIDTH-1:0] gpr_reg [28];
  logic [WIDTH-1:0] aux_reg [2];
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] out_port_reg [2];
  logic             illegal_reg;
  logic [1:0]       changed_reg;
  logic [WIDTH-1:0] port_pin [2];
  logic [WIDTH-1:0] sync_reg [2][SYNC_STAGES];
  logic             write_rejected;

  assign port_pin[0] = Port_In_0;
  assign port_pin[1] = Port_In_1;

  // Destinations 28/29 are read-only pins and 35-63 do not exist.
  assign write_rejected = Write_En &&
                          ((Sel_C == 6'd28) || (Sel_C == 6'd29) || (Sel_C > 6'd34));

  // General registers r0-r27: write when selected and enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 28; i++) gpr_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 28; i++) begin
        if (Write_En && (Sel_C == 6'(i))) gpr_reg[i] <= Data_C;
      end
    end
  end

  // Output ports (30/31), auxiliaries (32/33) and working register (34).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port_reg[0] <= '0;
      out_port_reg[1] <= '0;
      aux_reg[0]      <= '0;
      aux_reg[1]      <= '0;
      work_reg        <= '0;
    end else if (Write_En) begin
      case (Sel_C)
        6'd30:   out_port_reg[0] <= Data_C;
        6'd31:   out_port_reg[1] <= Data_C;
        6'd32:   aux_reg[0]      <= Data_C;
        6'd33:   aux_reg[1]      <= Data_C;
        6'd34:   work_reg        <= Data_C;
        default: ;
      endcase
    end
  end

  // Rejected-write flag, valid for the cycle after the offending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_reg <= 1'b0;
    else       illegal_reg <= write_rejected;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Input-port synchroniser chain plus change pulse aligned with the
      // cycle in which the last stage takes its new value.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_reg[gi][s] <= '0;
          changed_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi][0] <= port_pin[gi];
          for (int s = 1; s < SYNC_STAGES; s++) sync_reg[gi][s] <= sync_reg[gi][s-1];
          changed_reg[gi] <= (sync_reg[gi][SYNC_STAGES-2] != sync_reg[gi][SYNC_STAGES-1]);
        end
      end
    end
  endgenerate

  assign r0  = gpr_reg[0];   assign r1  = gpr_reg[1];
  assign r2  = gpr_reg[2];   assign r3  = gpr_reg[3];
  assign r4  = gpr_reg[4];   assign r5  = gpr_reg[5];
  assign r6  = gpr_reg[6];   assign r7  = gpr_reg[7];
  assign r8  = gpr_reg[8];   assign r9  = gpr_reg[9];
  assign r10 = gpr_reg[10];  assign r11 = gpr_reg[11];
  assign r12 = gpr_reg[12];  assign r13 = gpr_reg[13];
  assign r14 = gpr_reg[14];  assign r15 = gpr_reg[15];
  assign r16 = gpr_reg[16];  assign r17 = gpr_reg[17];
  assign r18 = gpr_reg[18];  assign r19 = gpr_reg[19];
  assign r20 = gpr_reg[20];  assign r21 = gpr_reg[21];
  assign r22 = gpr_reg[22];  assign r23 = gpr_reg[23];
  assign r24 = gpr_reg[24];  assign r25 = gpr_reg[25];
  assign r26 = gpr_reg[26];  assign r27 = gpr_reg[27];
  assign r28 = sync_reg[0][SYNC_STAGES-1];
  assign r29 = sync_reg[1][SYNC_STAGES-1];
  assign r32 = aux_reg[0];
  assign r33 = aux_reg[1];
  assign Working_Register = work_reg;
  assign Output_Port_0    = out_port_reg[0];
  assign Output_Port_1    = out_port_reg[1];
  assign Illegal_Write    = illegal_reg;
  assign Port_Changed     = changed_reg;

endmodule

// File: tb/tb_ev22_register_bank.sv
// Self-checking bench for ev22_register_bank: expected values go into a
// scoreboard queue as stimulus is driven and are compared once the DUT
// has produced its response.
module tb_ev22_register_bank;

  localparam int W = 16;
  // Observation ids: 0-27 gpr, 28/29 input ports, 30/31 output ports,
  // 32/33 aux, 34 working register, 35 Illegal_Write, 36 Port_Changed.
  localparam int ID_ILL = 35;
  localparam int ID_CHG = 36;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   Sel_C;
  logic         Write_En;
  logic [W-1:0] Data_C, Port_In_0, Port_In_1;
  logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13;
  logic [W-1:0] r14, r15, r16, r17, r18, r19, r20, r21, r22, r23, r24, r25;
  logic [W-1:0] r26, r27, r28, r29, r32, r33;
  logic [W-1:0] Working_Register, Output_Port_0, Output_Port_1;
  logic         Illegal_Write;
  logic [1:0]   Port_Changed;

  logic [W-1:0] obs [0:36];

  typedef struct {
    int          id;
    logic [W-1:0] val;
    string       tag;
  } exp_t;
  exp_t sb [$];

  int vectors = 0;
  int miscompares = 0;

  ev22_register_bank #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .Sel_C(Sel_C), .Write_En(Write_En), .Data_C(Data_C),
    .Port_In_0(Port_In_0), .Port_In_1(Port_In_1),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14),
    .r15(r15), .r16(r16), .r17(r17), .r18(r18), .r19(r19), .r20(r20), .r21(r21),
    .r22(r22), .r23(r23), .r24(r24), .r25(r25), .r26(r26), .r27(r27),
    .r28(r28), .r29(r29), .r32(r32), .r33(r33),
    .Working_Register(Working_Register), .Output_Port_0(Output_Port_0),
    .Output_Port_1(Output_Port_1), .Illegal_Write(Illegal_Write),
    .Port_Changed(Port_Changed)
  );

  always #5 clk = ~clk;

  assign obs[0]  = r0;   assign obs[1]  = r1;   assign obs[2]  = r2;
  assign obs[3]  = r3;   assign obs[4]  = r4;   assign obs[5]  = r5;
  assign obs[6]  = r6;   assign obs[7]  = r7;   assign obs[8]  = r8;
  assign obs[9]  = r9;   assign obs[10] = r10;  assign obs[11] = r11;
  assign obs[12] = r12;  assign obs[13] = r13;  assign obs[14] = r14;
  assign obs[15] = r15;  assign obs[16] = r16;  assign obs[17] = r17;
  assign obs[18] = r18;  assign obs[19] = r19;  assign obs[20] = r20;
  assign obs[21] = r21;  assign obs[22] = r22;  assign obs[23] = r23;
  assign obs[24] = r24;  assign obs[25] = r25;  assign obs[26] = r26;
  assign obs[27] = r27;  assign obs[28] = r28;  assign obs[29] = r29;
  assign obs[30] = Output_Port_0;  assign obs[31] = Output_Port_1;
  assign obs[32] = r32;  assign obs[33] = r33;
  assign obs[34] = Working_Register;
  assign obs[ID_ILL] = {15'b0, Illegal_Write};
  assign obs[ID_CHG] = {14'b0, Port_Changed};

  task automatic sb_push(input int id, input logic [W-1:0] val, input string tag);
    exp_t e;
    e.id = id; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drain the scoreboard against the current DUT outputs.
  task automatic sb_check();
    exp_t e;
    logic [W-1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs[e.id];
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s id=%0d observed=%h expected=%h", e.tag, e.id, o, e.val);
      end
      $display("vec %0d %s id=%0d obs=%h exp=%h", vectors, e.tag, e.id, o, e.val);
    end
  endtask

  // One clock edge, then settle at the falling edge before checking.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    sb_check();
  endtask

  task automatic drive(input logic en, input logic [5:0] sel, input logic [W-1:0] d);
    Write_En = en; Sel_C = sel; Data_C = d;
  endtask

  logic [W-1:0] model [0:34];

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'd0, '0);
    Port_In_0 = '0; Port_In_1 = '0;
    for (int i = 0; i < 35; i++) model[i] = '0;

    // Reset state: everything zero while reset is held.
    for (int i = 0; i <= ID_CHG; i++) sb_push(i, '0, "reset_state");
    step();
    reset = 1'b0;

    // Write r5 = A5A5; all else stays zero.
    drive(1'b1, 6'd5, 16'hA5A5);
    model[5] = 16'hA5A5;
    for (int i = 0; i < 35; i++) sb_push(i, model[i], "wr_r5");
    sb_push(ID_ILL, '0, "wr_r5_ill");
    step();

    // Write to read-only port 28, then to nonexistent 40 (back-to-back).
    drive(1'b1, 6'd28, 16'h1234);
    sb_push(28, '0, "wr28_r28");
    sb_push(ID_ILL, 16'd1, "wr28_ill");
    step();
    drive(1'b1, 6'd40, 16'h1234);
    sb_push(ID_ILL, 16'd1, "wr40_ill");
    sb_push(5, 16'hA5A5, "wr40_r5");
    step();

    // Write_En=0: nothing changes, flag clears.
    drive(1'b0, 6'd7, 16'hDEAD);
    sb_push(7, '0, "noen_r7");
    sb_push(ID_ILL, '0, "noen_ill");
    step();

    // Output port 0 then working register on consecutive edges.
    drive(1'b1, 6'd30, 16'h00FF);
    sb_push(30, 16'h00FF, "po0");
    sb_push(34, '0, "po0_wr");
    step();
    drive(1'b1, 6'd34, 16'hFF00);
    sb_push(34, 16'hFF00, "wr34");
    sb_push(30, 16'h00FF, "po0_hold");
    step();
    drive(1'b1, 6'd31, 16'h5A5A);
    sb_push(31, 16'h5A5A, "po1");
    step();

    // Port_In_1 step to BEEF: visible after two edges, one-cycle pulse.
    drive(1'b0, 6'd0, '0);
    Port_In_1 = 16'hBEEF;
    sb_push(29, '0, "pi1_e1");
    sb_push(ID_CHG, '0, "pi1_chg_e1");
    step();
    sb_push(29, 16'hBEEF, "pi1_e2");
    sb_push(28, '0, "pi0_e2");
    sb_push(ID_CHG, 16'd2, "pi1_chg_e2");
    step();
    sb_push(29, 16'hBEEF, "pi1_e3");
    sb_push(ID_CHG, '0, "pi1_chg_e3");
    step();

    // Fill r0-r27, r32, r33 with address-tagged values.
    for (int a = 0; a < 34; a++) begin
      if (a < 28 || a > 31) begin
        drive(1'b1, 6'(a), 16'h1000 + 16'(a));
        model[a] = 16'h1000 + 16'(a);
        sb_push(a, model[a], "fill");
        step();
      end
    end
    sb_push(3, 16'h1003, "fill_r3");
    sb_push(32, 16'h1020, "fill_r32");
    sb_push(33, 16'h1021, "fill_r33");
    sb_push(0, 16'h1000, "fill_r0");
    sb_check();

    // Reset mid-cycle during a write to r3: outputs clear at once.
    drive(1'b1, 6'd3, 16'h9999);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i <= ID_CHG; i++) sb_push(i, '0, "async_rst");
    sb_check();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    Port_In_1 = '0;
    drive(1'b0, 6'd3, 16'h9999);
    sb_push(3, '0, "post_rst_r3");
    step();

    // A write on the first edge after release is accepted.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 6'd33, 16'hC0DE);
    sb_push(33, 16'hC0DE, "first_edge_wr");
    sb_push(ID_ILL, '0, "first_edge_ill");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ev22_register_bank.md
# ev22_register_bank

Storage stage for the EV22 datapath. Holds general registers r0–r27, synchronised input ports PI0/PI1 (r28/r29), output ports PO0/PO1 (destinations 30/31), auxiliary registers r32/r33 and the working register (r34). Performs the single write-back per clock from the ALU result bus. Sits directly upstream of the operand-select stage: every stored value drives that stage's register inputs, which resolve Sel_A/Sel_B combinationally into Data_A/Data_B.

## Interface
Parameters:
- WIDTH, 16, register data width
- SYNC_STAGES, 2, flip-flop depth of the input-port synchronisers (legal: 2 or 3)

Ports:
- clk  input  1  single system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state immediately
- Sel_C  input  6  write-back destination address
- Write_En  input  1  commit Data_C to Sel_C on this rising edge
- Data_C  input  WIDTH  write-back data (ALU result)
- Port_In_0, Port_In_1  input  WIDTH  asynchronous external input pins
- r0 … r29, r32, r33  output  WIDTH  each stored register value
- Working_Register  output  WIDTH  r34 value
- Output_Port_0, Output_Port_1  output  WIDTH  registered external output pins
- Illegal_Write  output  1  one-cycle pulse: previous cycle's write was rejected
- Port_Changed  output  2  one-cycle pulse per port: synchronised value of PI0/PI1 changed

## Operation
- Reset (async assert): every register, both output ports, all synchroniser flops, Illegal_Write and Port_Changed go to 0. Deassertion is taken synchronously by the surrounding reset logic; the block requires no extra handling.
- Write decode on rising clk when Write_En=1:
  - Sel_C 0–27: r[Sel_C] <= Data_C
  - 28, 29: no write (input ports read-only); Illegal_Write=1 next cycle
  - 30, 31: Output_Port_0/1 <= Data_C
  - 32, 33: r32/r33 <= Data_C
  - 34: Working_Register <= Data_C
  - 35–63: no write; Illegal_Write=1 next cycle
- Write_En=0: no register changes; Illegal_Write=0 next cycle regardless of Sel_C.
- At most one destination written per cycle; all other registers hold.
- Input ports: each bit of Port_In_n passes through a SYNC_STAGES-deep flop chain; r28 = last stage for PI0, r29 for PI1. Updated every cycle independent of Write_En.
- Port_Changed[n] = 1 for one cycle when the r28/r29 value just loaded differs from its previous value; computed from registered values, not from pins.
- Data_C is stored unmodified, full WIDTH; no sign extension, truncation or arithmetic.

## Timing
- Write latency: value written at edge N appears on its output from edge N (after clock-to-Q) and is visible to the operand-select stage throughout cycle N+1. No write-to-read bypass; a read of the same address in cycle N returns the old value.
- Output ports change exactly one edge after the accepted write; no glitches (direct flop outputs).
- Input port latency: a pin change stable before edge N appears on r28/r29 after edge N+SYNC_STAGES−1; Port_Changed pulses in that same cycle.
- Illegal_Write asserted for exactly the cycle following the rejected write; back-to-back illegal writes hold it high continuously.
- Reset asserted mid-cycle with Write_En=1: reset wins; the write is lost, all outputs 0 within the reset propagation delay and held while reset=1.
- First edge after reset release: normal operation; a write on that edge is accepted.

## Test plan
- Reset then write 0xA5A5 to Sel_C=5, Write_En=1 -> r5=0xA5A5 one edge later, all other registers remain 0, Illegal_Write=0.
- Write 0x1234 to Sel_C=28 -> r28 unchanged (still synchronised pin value), Illegal_Write=1 for one cycle; same with Sel_C=40.
- Write 0x00FF to Sel_C=30 and then 0xFF00 to 34 on consecutive edges -> Output_Port_0=0x00FF after first edge, Working_Register=0xFF00 after second, Output_Port_0 holds.
- Port_In_1 steps 0x0000->0xBEEF (SYNC_STAGES=2) -> r29=0xBEEF two edges later, Port_Changed=2'b10 for exactly one cycle.
- Fill r0–r27, r32, r33 with address-tagged values (0x1000+addr), assert reset mid-cycle during a write to r3 -> all outputs 0 immediately, r3 not written after release.
- Write_En=0 with Sel_C=7, Data_C=0xDEAD -> r7 unchanged, Illegal_Write=0.
